// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch prefetch stage.
// Width helpers let parametrised instances derive index/count widths consistently.
package if_pkg;

    localparam int PC_INC = 4;

    localparam int DEF_NB         = 32;
    localparam int DEF_TAM_I      = 256;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int DEF_WORD_IDX_W = $clog2(DEF_TAM_I);
    localparam int DEF_COUNT_W    = $clog2(DEF_FIFO_DEPTH + 1);

    // Queue entry at the default datapath width; parametrised instances mirror this layout.
    typedef struct packed {
        logic [DEF_NB-1:0] pc;
        logic [DEF_NB-1:0] instr;
    } if_entry_t;

    function automatic int word_idx_w(input int tam_i);
        return $clog2(tam_i);
    endfunction

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_prefetch_stage_fetch_queue.sv
// Small synchronous FIFO holding prefetched {pc, instr} entries.
// Flush clears both pointers and the count; stored data is left as-is.
module fetch_queue
    import if_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_NB,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          head,
    output logic                      valid,
    output logic                      full,
    output logic [count_w(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    logic [WIDTH-1:0] slot_reg [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic push_ok;
    logic pop_ok;

    assign valid = (count_reg != '0);
    assign full  = (count_reg == CW'(DEPTH));

    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign pop_ok  = pop && valid;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            slot_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = slot_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage: fetch PC, debug-loadable instruction memory and a
// prefetch queue that keeps fetching while decode stalls.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int             NB         = DEF_NB,
    parameter int             TAM_I      = DEF_TAM_I,
    parameter int             FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [NB-1:0]  RESET_PC   = '0
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_step,
    input  logic                               i_stall,
    input  logic                               i_branch,
    input  logic [NB-1:0]                      i_branch_addr,
    input  logic                               i_jump,
    input  logic [NB-1:0]                      i_jump_addr,
    input  logic                               i_instruction_write_enable,
    input  logic [NB-1:0]                      i_instruction_address,
    input  logic [NB-1:0]                      i_instruction_data,
    output logic [NB-1:0]                      o_IF_pc,
    output logic [NB-1:0]                      o_IF_pc4,
    output logic [NB-1:0]                      o_IF_pc8,
    output logic [NB-1:0]                      o_instruction,
    output logic                               o_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count
);

    localparam int WIW = word_idx_w(TAM_I);
    localparam int CW  = count_w(FIFO_DEPTH);

    typedef struct packed {
        logic [NB-1:0] pc;
        logic [NB-1:0] instr;
    } entry_t;

    logic [NB-1:0] instr_mem [TAM_I];
    logic [NB-1:0] fetch_pc_reg;
    logic [NB-1:0] fetch_instr;
    logic [NB-1:0] out_pc_reg;
    logic [NB-1:0] out_instr_reg;

    logic          redirect;
    logic [NB-1:0] redirect_target;
    logic          q_push;
    logic          q_pop;
    logic          q_valid;
    logic          q_full;
    logic [CW-1:0] q_count;
    entry_t        q_din;
    entry_t        q_head;

    // Byte-address bits outside the word index are intentionally ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_instruction_address[NB-1:WIW+2], i_instruction_address[1:0],
                                i_branch_addr[1:0], i_jump_addr[1:0]};

    // Debug write port; asynchronous read so a same-word write returns old data this cycle.
    always_ff @(posedge i_clk) begin
        if (i_instruction_write_enable) begin
            instr_mem[i_instruction_address[WIW+1:2]] <= i_instruction_data;
        end
    end

    assign fetch_instr = instr_mem[fetch_pc_reg[WIW+1:2]];

    // Branch belongs to the older instruction, so it wins over a simultaneous jump.
    assign redirect        = i_step && (i_branch || i_jump);
    assign redirect_target = i_branch ? {i_branch_addr[NB-1:2], 2'b00}
                                      : {i_jump_addr[NB-1:2], 2'b00};

    assign q_pop  = i_step && !i_stall && q_valid;
    assign q_push = i_step && !redirect && (!q_full || q_pop);
    assign q_din  = '{pc: fetch_pc_reg, instr: fetch_instr};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_pc_reg <= RESET_PC;
        end else if (redirect) begin
            fetch_pc_reg <= redirect_target;
        end else if (q_push) begin
            fetch_pc_reg <= fetch_pc_reg + NB'(PC_INC);
        end
    end

    fetch_queue #(
        .WIDTH (2 * NB),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_queue (
        .clk   (i_clk),
        .srst  (i_reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect),
        .din   (q_din),
        .head  (q_head),
        .valid (q_valid),
        .full  (q_full),
        .count (q_count)
    );

    // Remember the last valid head so outputs hold steady while the queue is empty.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_pc_reg    <= '0;
            out_instr_reg <= '0;
        end else if (q_valid) begin
            out_pc_reg    <= q_head.pc;
            out_instr_reg <= q_head.instr;
        end
    end

    assign o_IF_pc       = q_valid ? q_head.pc    : out_pc_reg;
    assign o_instruction = q_valid ? q_head.instr : out_instr_reg;
    assign o_IF_pc4      = o_IF_pc + NB'(PC_INC);
    assign o_IF_pc8      = o_IF_pc + NB'(2 * PC_INC);
    assign o_valid       = q_valid;
    assign o_fifo_count  = q_count;

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
- Parametrised fetch stage that decouples instruction-memory reads from decode with a FIFO_DEPTH-entry prefetch queue.
- Holds the fetch PC and a debug-loadable instruction memory.
- Fetches ahead while decode stalls, and flushes the queue on branch/jump redirect.
- Sits between the debug loader / hazard unit and the IF/ID register; presents one {pc, pc4, pc8, instruction, valid} entry per cycle.

Parameters:
- NB, 32, datapath/address width in bits.
- TAM_I, 256, instruction memory depth in words (power of two).
- FIFO_DEPTH, 4, prefetch queue entries (power of two, >=2).
- RESET_PC, 0, fetch PC after reset (word aligned).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_step  in  1  global advance enable (debug single-step); when 0 the block holds all PC/queue state.
- i_stall  in  1  from stall unit: decode not accepting; queue head held.
- i_branch  in  1  branch taken, redirect to i_branch_addr.
- i_branch_addr  in  NB  branch target (byte address).
- i_jump  in  1  jump, redirect to i_jump_addr.
- i_jump_addr  in  NB  jump target (byte address).
- i_instruction_write_enable  in  1  debug memory write strobe.
- i_instruction_address  in  NB  debug write byte address.
- i_instruction_data  in  NB  debug write data.
- o_IF_pc  out  NB  PC of queue-head instruction.
- o_IF_pc4  out  NB  o_IF_pc+4.
- o_IF_pc8  out  NB  o_IF_pc+8.
- o_instruction  out  NB  queue-head instruction.
- o_valid  out  1  queue head holds a valid entry.
- o_fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries.

Behaviour:
- Reset (sync, priority over everything, including i_step=0):
  - fetch_pc<=RESET_PC; queue emptied.
  - o_valid=0, o_fifo_count=0, o_instruction=0, o_IF_pc=0, o_IF_pc4=4, o_IF_pc8=8.
  - Memory contents are not cleared.
- Memory:
  - Word index = address[clog2(TAM_I)+1:2]; upper bits ignored, so addresses wrap modulo TAM_I.
  - Debug write occurs on any clock edge with write_enable=1, independent of i_step and i_stall.
  - Read is asynchronous at fetch_pc.
  - A write and a read of the same word in one cycle: the read returns old data.
- Pop: i_step & !i_stall & o_valid.
- Push: i_step & !redirect & (count<FIFO_DEPTH | pop). Each push enqueues {fetch_pc, mem[fetch_pc]} and sets fetch_pc+=4 (wraps modulo 2^NB).
  - Push and pop in the same cycle when full is allowed; count is unchanged.
- Redirect: i_step & (i_branch | i_jump).
  - Branch wins over jump when both are high (older instruction).
  - Next edge: queue flushed (count=0, o_valid=0), no push, fetch_pc<=target with bits [1:0] forced to 0.
  - An entry popped in the redirect cycle is still consumed normally.
- Latency:
  - An entry pushed at edge N appears at the head (o_valid=1) after edge N when the queue was empty.
  - First instruction after reset or redirect: valid one step-cycle later.
- Outputs are driven from the head entry. When o_valid=0, outputs hold their last value; the consumer must not use them.
- i_step=0: no push, no pop, no redirect; outputs stable.

Decomposition:
- Package if_pkg holds:
  - localparams for PC increment (4), word-index width, and count width.
  - The queue-entry typedef {pc[NB], instr[NB]}.
- Sub-module fetch_queue: a synchronous FIFO with push/pop/flush, head read, and count. It has circular read/write pointers of width clog2(FIFO_DEPTH) and flush resets both pointers.
- PC register, redirect mux and memory stay in the top module.

Test Plan:
- Reset, then load mem[0..3]=0x11,0x22,0x33,0x44 via debug writes; i_step=1, i_stall=0.
  - o_valid rises 1 cycle after the first step.
  - Outputs in order: (pc 0, 0x11), (4, 0x22), (8, 0x33), (12, 0x44); o_IF_pc8 = pc+8.
- i_stall=1 for 10 cycles.
  - o_fifo_count saturates at 4; head stays pc 0; fetch_pc stops at 16.
  - On release, entries pc 0,4,8,12,16 appear in order, one per cycle, with no loss or duplication.
- With 3 entries queued, pulse i_branch=1, addr=0x42.
  - Next cycle o_valid=0, count=0.
  - Following cycle head pc=0x40 with mem[16].
- i_branch=1 (0x20) and i_jump=1 (0x80) in the same cycle: the next head pc is 0x20.
- i_step=0 while the queue is partly full with i_stall=0 and a debug write to mem[5]=0xAB.
  - Count and outputs are frozen; the write lands.
  - Later fetch of pc 20 returns 0xAB.
- Assert i_reset mid-stream with count=3 and i_step=0: next edge count=0, o_valid=0, fetch resumes at RESET_PC; memory preserved.
